// File: rtl/aes_128_ctrl_pkg.sv
// Shared types and widths for the AES-128 key switch controller.
package aes_128_ctrl_pkg;

    localparam int unsigned KEY_HALF_W = 64;
    localparam int unsigned BLOCK_W    = 128;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitDrain,
        StSwitch,
        StSettle
    } ctrl_state_e;

endpackage

// File: rtl/aes_128_key_serializer.sv
// Splits accepted 128-bit round key words into two registered 64-bit writes, low half first.
module aes_128_key_serializer
    import aes_128_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  kill_n,
    input  logic                  enable,
    input  logic                  key_valid,
    input  logic [BLOCK_W-1:0]    key_data,
    output logic                  key_ready,
    output logic                  en_wr,
    output logic [KEY_HALF_W-1:0] key_round_wr,
    output logic                  hi_emit
);

    logic                  pend_q;
    logic [KEY_HALF_W-1:0] hi_q;
    logic                  en_wr_q;
    logic [KEY_HALF_W-1:0] key_round_wr_q;
    logic                  hi_emit_q;
    logic                  accept;

    // Ready while the cycle's output is the high half (or nothing): the holding register is free.
    assign key_ready = enable && !pend_q;
    assign accept    = key_valid && key_ready;

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            pend_q         <= 1'b0;
            hi_q           <= '0;
            en_wr_q        <= 1'b0;
            key_round_wr_q <= '0;
            hi_emit_q      <= 1'b0;
        end else if (accept) begin
            pend_q         <= 1'b1;
            hi_q           <= key_data[BLOCK_W-1:KEY_HALF_W];
            en_wr_q        <= 1'b1;
            key_round_wr_q <= key_data[KEY_HALF_W-1:0];
            hi_emit_q      <= 1'b0;
        end else if (pend_q) begin
            pend_q         <= 1'b0;
            en_wr_q        <= 1'b1;
            key_round_wr_q <= hi_q;
            hi_emit_q      <= 1'b1;
        end else begin
            en_wr_q        <= 1'b0;
            key_round_wr_q <= '0;
            hi_emit_q      <= 1'b0;
        end
    end

    assign en_wr        = en_wr_q;
    assign key_round_wr = key_round_wr_q;
    assign hi_emit      = hi_emit_q;

endmodule

// File: rtl/aes_128_key_switch_ctrl.sv
// Loads a new round key set into the core shadow buffer alongside live traffic, then drains the
// core and pulses switch_key.
module aes_128_key_switch_ctrl
    import aes_128_ctrl_pkg::*;
#(
    parameter int unsigned KEY_ROUNDS    = 11,
    parameter int unsigned CNT_W         = 6,
    parameter int unsigned DRAIN_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  kill_n,
    input  logic                  cfg_start,
    input  logic                  key_valid,
    input  logic [BLOCK_W-1:0]    key_data,
    output logic                  key_ready,
    input  logic                  s_valid,
    input  logic [BLOCK_W-1:0]    s_data,
    output logic                  s_ready,
    output logic                  in_en,
    output logic [BLOCK_W-1:0]    in_data,
    output logic                  en_wr,
    output logic [KEY_HALF_W-1:0] key_round_wr,
    output logic                  switch_key,
    input  logic                  out_en,
    input  logic                  idle,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic [CNT_W-1:0]      inflight
);

    localparam int unsigned WCNT_W = $clog2(KEY_ROUNDS + 1);
    localparam int unsigned TMO_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W:0] MaxInflight = {1'b0, {CNT_W{1'b1}}};

    ctrl_state_e         state_q, state_d;
    logic [WCNT_W-1:0]   word_cnt_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic                in_en_q;
    logic [BLOCK_W-1:0]  in_data_q;
    logic                switch_key_q, done_q, err_q, err_d;
    logic                ser_enable, ser_hi_emit, key_acc, s_acc;

    assign ser_enable = (state_q == StLoad) && (word_cnt_q < WCNT_W'(KEY_ROUNDS));
    assign key_acc    = key_valid && key_ready;

    aes_128_key_serializer u_ser (
        .clk          (clk),
        .kill_n       (kill_n),
        .enable       (ser_enable),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_ready    (key_ready),
        .en_wr        (en_wr),
        .key_round_wr (key_round_wr),
        .hi_emit      (ser_hi_emit)
    );

    // The block already presented on in_en counts as outstanding so the counter cannot wrap.
    assign s_ready = ((state_q == StIdle) || (state_q == StLoad)) &&
                     (({1'b0, inflight_q} + {{CNT_W{1'b0}}, in_en_q}) < MaxInflight);
    assign s_acc   = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (cfg_start) state_d = StLoad;
            StLoad:      if (ser_hi_emit && (word_cnt_q == WCNT_W'(KEY_ROUNDS))) state_d = StWaitDrain;
            StWaitDrain: if ((inflight_q == '0) && idle && !in_en_q) state_d = StSwitch;
            StSwitch:    state_d = StSettle;
            StSettle:    state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (in_en_q && !out_en) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!in_en_q && out_en && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // Fires once per drain: the counter saturates one past the compare value.
    assign err_d = (state_q == StWaitDrain) && (state_d == StWaitDrain) &&
                   (tmo_q == TMO_W'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_q      <= StIdle;
            word_cnt_q   <= '0;
            tmo_q        <= '0;
            inflight_q   <= '0;
            in_en_q      <= 1'b0;
            in_data_q    <= '0;
            switch_key_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            in_en_q      <= s_acc;
            in_data_q    <= s_acc ? s_data : '0;
            switch_key_q <= (state_d == StSwitch);
            done_q       <= (state_d == StSettle);
            err_q        <= err_d;
            if (state_q == StIdle) begin
                word_cnt_q <= '0;
            end else if (key_acc) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if (state_q != StWaitDrain) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_W'(DRAIN_TIMEOUT)) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign in_en       = in_en_q;
    assign in_data     = in_data_q;
    assign switch_key  = switch_key_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign inflight    = inflight_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_aes_128_key_switch_ctrl.sv
// Directed and randomized bench for aes_128_key_switch_ctrl against a cycle-level reference model.
module tb_aes_128_key_switch_ctrl;

    localparam int unsigned KR   = 11;
    localparam int unsigned CW   = 6;
    localparam int unsigned TMO  = 16;
    localparam int          MAXI = 63;

    logic         clk = 1'b0;
    logic         kill_n, cfg_start, key_valid, s_valid, out_en, idle;
    logic [127:0] key_data, s_data;
    logic         key_ready, s_ready, in_en, en_wr, switch_key, busy, done, err_timeout;
    logic [127:0] in_data;
    logic [63:0]  key_round_wr;
    logic [CW-1:0] inflight;

    aes_128_key_switch_ctrl #(
        .KEY_ROUNDS    (KR),
        .CNT_W         (CW),
        .DRAIN_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .kill_n       (kill_n),
        .cfg_start    (cfg_start),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_ready    (key_ready),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .in_en        (in_en),
        .in_data      (in_data),
        .en_wr        (en_wr),
        .key_round_wr (key_round_wr),
        .switch_key   (switch_key),
        .out_en       (out_en),
        .idle         (idle),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .inflight     (inflight)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 load, 2 drain, 3 switch, 4 settle.
    int           mph, m_words, m_halves, m_infl, m_dc;
    logic [63:0]  m_q[$];
    logic         m_en_wr, m_in_en;
    logic [63:0]  m_krw;
    logic [127:0] m_in_data;

    // Observation trackers for directed checks.
    int           cyc = 0;
    int           enwr_cnt, sw_cnt, done_cnt, err_cnt, max_infl;
    int           last_enwr_cyc, sw_cyc, done_cyc, err_cyc;
    logic [63:0]  krw_log[$];
    logic [127:0] first_in_data;
    logic         got_in;

    logic [127:0] rk[KR];

    function automatic logic [127:0] brev(input logic [127:0] w);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = w[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic exp_key_ready();
        return (mph == 1) && (m_words < KR) && (m_q.size() == 0);
    endfunction

    function automatic logic exp_s_ready();
        return (mph <= 1) && ((m_infl + (m_in_en ? 1 : 0)) < MAXI);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mph = 0; m_words = 0; m_halves = 0; m_infl = 0; m_dc = 0;
        m_q.delete();
        m_en_wr = 1'b0; m_krw = '0; m_in_en = 1'b0; m_in_data = '0;
    endtask

    task automatic clr_trk();
        enwr_cnt = 0; sw_cnt = 0; done_cnt = 0; err_cnt = 0; max_infl = 0;
        last_enwr_cyc = -1; sw_cyc = -1; done_cyc = -1; err_cyc = -1;
        krw_log.delete(); got_in = 1'b0; first_in_data = '0;
    endtask

    task automatic model_step(input logic ak, input logic as_);
        int nph;
        nph = mph;
        case (mph)
            0: if (cfg_start) begin nph = 1; m_words = 0; m_halves = 0; end
            1: if (m_en_wr && (m_halves == 2 * KR)) nph = 2;
            2: if ((m_infl == 0) && idle && !m_in_en) nph = 3;
            3: nph = 4;
            default: nph = 0;
        endcase
        m_dc = ((mph == 2) && (nph == 2)) ? m_dc + 1 : 0;
        if (ak) begin
            m_words++;
            m_q.push_back(key_data[63:0]);
            m_q.push_back(key_data[127:64]);
        end
        if (m_q.size() > 0) begin
            m_krw = m_q.pop_front(); m_en_wr = 1'b1; m_halves++;
        end else begin
            m_krw = '0; m_en_wr = 1'b0;
        end
        if (m_in_en && !out_en) m_infl++;
        else if (!m_in_en && out_en && (m_infl > 0)) m_infl--;
        m_in_en   = as_;
        m_in_data = as_ ? s_data : '0;
        mph       = nph;
    endtask

    // One clock: check handshakes before the edge, advance the model, check registered outputs.
    task automatic tick();
        logic ak, as_;
        #1;
        chk("key_ready", key_ready, exp_key_ready());
        chk("s_ready", s_ready, exp_s_ready());
        ak  = key_valid && exp_key_ready();
        as_ = s_valid && exp_s_ready();
        @(posedge clk);
        if (!kill_n) model_reset();
        else model_step(ak, as_);
        #1;
        cyc++;
        chk("en_wr", en_wr, m_en_wr);
        chk("key_round_wr", key_round_wr, m_krw);
        chk("in_en", in_en, m_in_en);
        chk("in_data", in_data, m_in_data);
        chk("switch_key", switch_key, mph == 3);
        chk("done", done, mph == 4);
        chk("busy", busy, mph != 0);
        chk("err_timeout", err_timeout, (mph == 2) && (m_dc == TMO));
        chk("inflight", inflight, m_infl);
        if (en_wr) begin enwr_cnt++; krw_log.push_back(key_round_wr); last_enwr_cyc = cyc; end
        if (switch_key) begin sw_cnt++; sw_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err_timeout) begin err_cnt++; err_cyc = cyc; end
        if (in_en && !got_in) begin got_in = 1'b1; first_in_data = in_data; end
        if (int'(inflight) > max_infl) max_infl = int'(inflight);
    endtask

    task automatic drive_key();
        key_valid = (mph == 1) && (m_words < KR);
        key_data  = key_valid ? rk[m_words] : '0;
    endtask

    task automatic settle_idle();
        cfg_start = 0; s_valid = 0; out_en = 1; idle = 1;
        for (int i = 0; i < 500 && (mph != 0 || m_infl != 0 || m_in_en); i++) begin
            drive_key();
            tick();
        end
        chk("settled_idle", busy, 1'b0);
        out_en = 0;
    endtask

    initial begin
        int sent, outs, last_out_cyc, rel_cyc;
        rk[0]  = brev(128'h000102030405060708090a0b0c0d0e0f);
        rk[1]  = brev(128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        rk[2]  = brev(128'hb692cf0b643dbdf1be9bc5006830b3fe);
        rk[3]  = brev(128'hb6ff744ed2c2c9bf6c590cbf0469bf41);
        rk[4]  = brev(128'h47f7f7bc95353e03f96c32bcfd058dfd);
        rk[5]  = brev(128'h3caaa3e8a99f9deb50f3af57adf622aa);
        rk[6]  = brev(128'h5e390f7df7a69296a7553dc10aa31f6b);
        rk[7]  = brev(128'h14f9701ae35fe28c440adf4d4ea9c026);
        rk[8]  = brev(128'h47438735a41c65b9e016baf4aebf7ad2);
        rk[9]  = brev(128'h549932d1f08557681093ed9cbe2c974e);
        rk[10] = brev(128'h13111d7fe3944a17f307a78b4d2b30c5);

        kill_n = 0; cfg_start = 0; key_valid = 0; key_data = '0;
        s_valid = 0; s_data = '0; out_en = 0; idle = 1;
        model_reset(); clr_trk();

        // Reset held for five cycles.
        for (int i = 0; i < 5; i++) tick();
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        kill_n = 1;
        tick();

        // Key load with three blocks during LOAD, then drain.
        clr_trk();
        cfg_start = 1; tick(); cfg_start = 0;
        chk("busy_after_start", busy, 1'b1);
        sent = 0; outs = 0; last_out_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            drive_key();
            s_valid = (mph == 1) && (sent < 3);
            s_data  = (sent == 0) ? 128'hffeeddccbbaa99887766554433221100
                                  : {$urandom, $urandom, $urandom, $urandom};
            out_en  = (mph == 2) && (outs < 3) && (i % 3 == 0);
            tick();
            if (m_in_en) sent++;
            if (out_en) begin outs++; last_out_cyc = cyc; end
            if (done_cnt > 0 && mph == 0) break;
        end
        s_valid = 0; out_en = 0; key_valid = 0;
        chk("load_enwr_count", enwr_cnt, 22);
        chk("load_krw0", krw_log.size() > 0 ? krw_log[0] : 64'hx, 64'h0706050403020100);
        chk("load_krw1", krw_log.size() > 1 ? krw_log[1] : 64'hx, 64'h0f0e0d0c0b0a0908);
        chk("load_switch_count", sw_cnt, 1);
        chk("load_done_after_switch", done_cyc, sw_cyc + 1);
        chk("load_max_inflight", max_infl, 3);
        chk("load_switch_after_drain", sw_cyc > last_out_cyc, 1'b1);
        chk("load_first_in_data", first_in_data, 128'hffeeddccbbaa99887766554433221100);

        // Drain timeout: idle held low well past the limit, then released.
        clr_trk();
        idle = 0; rel_cyc = -1;
        cfg_start = 1; tick(); cfg_start = 0;
        for (int i = 0; i < 300; i++) begin
            drive_key();
            if (mph == 2 && m_dc >= 25 && !idle) begin idle = 1; rel_cyc = cyc; end
            tick();
            if (done_cnt > 0 && mph == 0) break;
        end
        key_valid = 0; idle = 1;
        chk("tmo_err_count", err_cnt, 1);
        chk("tmo_err_offset", err_cyc - last_enwr_cyc, 17);
        chk("tmo_switch_after_release", (rel_cyc >= 0) && (sw_cyc > rel_cyc), 1'b1);
        chk("tmo_switch_count", sw_cnt, 1);

        // Fill to the in-flight limit, then in_en and out_en together.
        settle_idle();
        s_valid = 1; out_en = 0;
        for (int i = 0; i < 70; i++) begin s_data = {$urandom, $urandom, $urandom, $urandom}; tick(); end
        chk("full_inflight", inflight, 63);
        chk("full_s_ready", s_ready, 1'b0);
        out_en = 1; tick();
        out_en = 0; tick();
        out_en = 1; tick();
        chk("simul_inflight", inflight, 62);
        s_valid = 0;
        settle_idle();

        // Randomized traffic, key loads, idle stalls and stray cfg_start pulses.
        for (int i = 0; i < 1500; i++) begin
            cfg_start = ($urandom_range(0, 9) == 0);
            key_valid = ($urandom_range(0, 3) != 0);
            key_data  = {$urandom, $urandom, $urandom, $urandom};
            s_valid   = ($urandom_range(0, 1) == 0);
            s_data    = {$urandom, $urandom, $urandom, $urandom};
            out_en    = ($urandom_range(0, 2) == 0);
            idle      = ($urandom_range(0, 7) != 0);
            tick();
        end
        settle_idle();

        // Abort mid-LOAD with an ignored cfg_start along the way.
        clr_trk();
        cfg_start = 1; tick(); cfg_start = 0;
        for (int i = 0; i < 100 && m_words < 5; i++) begin
            drive_key();
            cfg_start = (m_words == 2);
            tick();
        end
        cfg_start = 0; key_valid = 0;
        chk("abort_words_loaded", enwr_cnt >= 8, 1'b1);
        kill_n = 0; model_reset();
        #1;
        chk("abort_busy_async", busy, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        kill_n = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_switch", sw_cnt, 0);
        chk("abort_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
